bp_fe_cce_responder: RTL and testbench
======================================

# bp_fe_cce_responder

Single-transaction coherence-directory responder that closes the loop for the front-end I$ LCE. It consumes LCE requests (cached read miss, uncached read) and fetches the line or dword from memory over the CCE memory interface. It then issues the LCE commands the I$ LCE waits on (data, set-tag, uncached data) and retires the transaction on the LCE's coherence ack. It sits on the ME side of the LCE–CCE network and serves as the minimal CCE for FE-only test configurations and for bring-up.

## Interface
Parameters:
- bp_params_p, e_bp_inv_cfg: processor config. Supplies paddr_width_p, lce_assoc_p, cce_block_width_p, lce_id_width_p, cce_id_width_p and the derived lce_cce_req/resp, lce_cmd and cce_mem_msg widths.
- cce_id_p, 0: this CCE's id. Placed in every lce_cmd src_id.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- lce_req_i  in  lce_cce_req_width_lp  LCE request (bp_lce_cce_req_s)
- lce_req_v_i  in  1  request valid
- lce_req_yumi_o  out  1  request consumed this cycle
- lce_resp_i  in  lce_cce_resp_width_lp  LCE response (bp_lce_cce_resp_s)
- lce_resp_v_i  in  1  response valid
- lce_resp_yumi_o  out  1  response consumed
- lce_cmd_o  out  lce_cmd_width_lp  command to LCE (bp_lce_cmd_s)
- lce_cmd_v_o  out  1  command valid
- lce_cmd_ready_i  in  1  LCE command network ready
- mem_cmd_o  out  cce_mem_msg_width_lp  memory command
- mem_cmd_v_o  out  1  memory command valid
- mem_cmd_ready_i  in  1  memory ready
- mem_resp_i  in  cce_mem_msg_width_lp  memory response
- mem_resp_v_i  in  1  memory response valid
- mem_resp_yumi_o  out  1  memory response consumed
- error_o  out  1  sticky protocol-error flag

## Operation
- Registers captured on request accept: addr, src_id, lru_way_id, msg_type, non_exclusive. Data register: one cce_block_width_p line, loaded from mem_resp.
- FSM states: e_ready, e_mem_cmd, e_mem_resp, e_data_cmd, e_set_tag_cmd, e_wait_ack, e_uc_data_cmd.
- e_ready transitions:
  - lce_req_v_i=1 → yumi the request and capture its fields.
  - msg_type rd or wr → e_mem_cmd with cached=1. The address is block-aligned (low log2(cce_block_width_p/8) bits zeroed).
  - msg_type uc_rd → e_mem_cmd with cached=0. The address is forwarded unmodified with size 8 B.
  - Any other msg_type → yumi, set error_o, stay in e_ready.
- e_mem_cmd: assert mem_cmd_v_o. The command is e_mem_msg_rd (cached) or e_mem_msg_uc_rd (uncached), with payload lce_id = src_id and way_id = lru_way_id. On mem_cmd_ready_i go to e_mem_resp.
- e_mem_resp: mem_resp_yumi_o = mem_resp_v_i. On the handshake, latch the data, then go to e_data_cmd (cached) or e_uc_data_cmd (uncached).
- e_data_cmd: lce_cmd msg_type e_lce_cmd_data, dst_id = src_id, way_id, addr, full line data. On lce_cmd_ready_i go to e_set_tag_cmd.
- e_set_tag_cmd: msg_type e_lce_cmd_set_tag, state = e_COH_S if non_exclusive, else e_COH_E. On ready go to e_wait_ack.
- e_wait_ack: lce_resp_yumi_o = lce_resp_v_i.
  - e_lce_cce_coh_ack from src_id with matching addr → e_ready.
  - Any other response → consumed, error_o set, stay in e_wait_ack.
- e_uc_data_cmd: msg_type e_lce_cmd_uc_data, low 64 b of the latched data, same addr. On ready go to e_ready; no ack is expected.
- lce_req_yumi_o=0 outside e_ready.
- Responses are consumed only in e_wait_ack; outside e_wait_ack, lce_resp_yumi_o=0.
- mem_resp_v_i outside e_mem_resp: consumed and error_o set.
- error_o clears only on reset.

## Timing
- Reset: asynchronous. State → e_ready; every v_o/yumi_o → 0; error_o → 0; the field and data registers → 0.
- Reset mid-transaction abandons the transaction, with no further commands issued.
- lce_req_yumi_o is combinational with lce_req_v_i in e_ready. mem_cmd_v_o rises the cycle after accept.
- Cached read, zero-wait memory and network: accept at cycle 0, mem_cmd at 1, mem_resp at 2, data_cmd at 3, set_tag at 4. The earliest possible ack is at cycle 5, and the next request can be accepted at 6.
- Uncached read, same conditions: uc_data_cmd at cycle 3; the next request can be accepted at cycle 4.
- Outputs hold stable while v_o=1 and ready=0. All payload fields come from registers, with no combinational path from inputs to payload.
- Back-to-back: a request present in the cycle the FSM returns to e_ready is accepted that cycle.

## Test plan
- Cached miss: rd, addr 0x8000_1234, src 1, way 3, non_excl. Expect mem rd at 0x8000_1200, then data cmd with way 3 and dst 1, then set_tag with e_COH_S. coh_ack is yumi'd and the FSM returns to e_ready; error_o stays 0.
- Uncached read: uc_rd, addr 0x0010_0004. Expect mem uc_rd at 0x0010_0004 with size 8, then uc_data cmd carrying mem data[63:0]. No ack is waited for; a second request is accepted 4 cycles after the first.
- Backpressure: hold lce_cmd_ready_i=0 for 5 cycles in e_data_cmd and mem_cmd_ready_i=0 for 3 cycles. Outputs must hold stable; the command sequence is unchanged.
- Protocol errors:
  - A wrong-address ack in e_wait_ack → consumed, error_o=1, and the FSM keeps waiting; the correct ack then retires the transaction.
  - A stray mem_resp in e_ready → error_o=1.
- Reset mid-op: assert reset_i in e_wait_ack, asynchronously. All valids drop in the same cycle; after release a new rd completes normally.

Source files
------------

// File: rtl/bp_fe_cce_responder.sv
// rtl/bp_fe_cce_responder.sv - minimal single-transaction CCE serving the front-end I$ LCE
module bp_fe_cce_responder #(
    parameter int paddr_width_p     = 40,
    parameter int lce_assoc_p       = 8,
    parameter int cce_block_width_p = 512,
    parameter int lce_id_width_p    = 4,
    parameter int cce_id_width_p    = 4,
    parameter int cce_id_p          = 0,
    localparam int way_width_lp          = $clog2(lce_assoc_p),
    localparam int lce_cce_req_width_lp  = 3 + lce_id_width_p + 1 + way_width_lp + paddr_width_p,
    localparam int lce_cce_resp_width_lp = 2 + lce_id_width_p + paddr_width_p,
    localparam int lce_cmd_width_lp      = 3 + lce_id_width_p + cce_id_width_p + way_width_lp + 2
                                           + paddr_width_p + cce_block_width_p,
    localparam int cce_mem_msg_width_lp  = 3 + 3 + lce_id_width_p + way_width_lp + paddr_width_p
                                           + cce_block_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [lce_cce_req_width_lp-1:0]  lce_req_i,
    input  logic                             lce_req_v_i,
    output logic                             lce_req_yumi_o,
    input  logic [lce_cce_resp_width_lp-1:0] lce_resp_i,
    input  logic                             lce_resp_v_i,
    output logic                             lce_resp_yumi_o,
    output logic [lce_cmd_width_lp-1:0]      lce_cmd_o,
    output logic                             lce_cmd_v_o,
    input  logic                             lce_cmd_ready_i,
    output logic [cce_mem_msg_width_lp-1:0]  mem_cmd_o,
    output logic                             mem_cmd_v_o,
    input  logic                             mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0]  mem_resp_i,
    input  logic                             mem_resp_v_i,
    output logic                             mem_resp_yumi_o,
    output logic                             error_o
);

    localparam int block_off_lp = $clog2(cce_block_width_p / 8);

    // Message encodings shared with the LCE and memory side
    localparam logic [2:0] e_lce_req_rd    = 3'd0;
    localparam logic [2:0] e_lce_req_wr    = 3'd1;
    localparam logic [2:0] e_lce_req_uc_rd = 3'd2;
    localparam logic [1:0] e_lce_cce_coh_ack = 2'd0;
    localparam logic [2:0] e_lce_cmd_set_tag = 3'd1;
    localparam logic [2:0] e_lce_cmd_data    = 3'd2;
    localparam logic [2:0] e_lce_cmd_uc_data = 3'd3;
    localparam logic [1:0] e_COH_I = 2'd0;
    localparam logic [1:0] e_COH_S = 2'd1;
    localparam logic [1:0] e_COH_E = 2'd2;
    localparam logic [2:0] e_mem_msg_rd    = 3'd0;
    localparam logic [2:0] e_mem_msg_uc_rd = 3'd1;
    localparam logic [2:0] e_mem_size_8    = 3'd3;

    typedef struct packed {
        logic [2:0]                msg_type;
        logic [lce_id_width_p-1:0] src_id;
        logic                      non_exclusive;
        logic [way_width_lp-1:0]   lru_way_id;
        logic [paddr_width_p-1:0]  addr;
    } lce_req_s;

    typedef struct packed {
        logic [1:0]                msg_type;
        logic [lce_id_width_p-1:0] src_id;
        logic [paddr_width_p-1:0]  addr;
    } lce_resp_s;

    typedef struct packed {
        logic [2:0]                   msg_type;
        logic [lce_id_width_p-1:0]    dst_id;
        logic [cce_id_width_p-1:0]    src_id;
        logic [way_width_lp-1:0]      way_id;
        logic [1:0]                   state;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } lce_cmd_s;

    typedef struct packed {
        logic [2:0]                   msg_type;
        logic [2:0]                   size;
        logic [lce_id_width_p-1:0]    lce_id;
        logic [way_width_lp-1:0]      way_id;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_block_width_p-1:0] data;
    } mem_msg_s;

    typedef enum logic [2:0] {
        e_ready, e_mem_cmd, e_mem_resp, e_data_cmd, e_set_tag_cmd, e_wait_ack, e_uc_data_cmd
    } state_e;

    state_e state_r, state_n;

    lce_req_s  req;
    lce_resp_s resp;
    mem_msg_s  mem_resp;
    lce_cmd_s  cmd;
    mem_msg_s  mem_cmd;

    logic [paddr_width_p-1:0]     addr_r;
    logic [lce_id_width_p-1:0]    src_id_r;
    logic [way_width_lp-1:0]      lru_way_r;
    logic [2:0]                   msg_type_r;
    logic                         non_excl_r;
    logic [cce_block_width_p-1:0] data_r;
    logic                         error_r;

    logic cached;
    logic req_ok;
    logic ack_ok;
    logic err_set;
    logic unused_mem_resp_hdr;

    assign req      = lce_req_i;
    assign resp     = lce_resp_i;
    assign mem_resp = mem_resp_i;
    assign unused_mem_resp_hdr = ^mem_resp_i[cce_mem_msg_width_lp-1:cce_block_width_p];

    assign cached = (msg_type_r != e_lce_req_uc_rd);
    assign req_ok = (req.msg_type == e_lce_req_rd) || (req.msg_type == e_lce_req_wr)
                    || (req.msg_type == e_lce_req_uc_rd);
    assign ack_ok = (resp.msg_type == e_lce_cce_coh_ack) && (resp.src_id == src_id_r)
                    && (resp.addr == addr_r);
    assign error_o = error_r;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= e_ready;
        else         state_r <= state_n;
    end

    // Next-state, handshakes and protocol-error detection
    always_comb begin
        state_n         = state_r;
        lce_req_yumi_o  = 1'b0;
        lce_resp_yumi_o = 1'b0;
        lce_cmd_v_o     = 1'b0;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        err_set         = 1'b0;
        case (state_r)
            e_ready: begin
                // Reset holds the FSM here, so yumi is masked to keep it quiet during reset
                lce_req_yumi_o = lce_req_v_i & ~reset_i;
                if (lce_req_v_i) begin
                    if (req_ok) state_n = e_mem_cmd;
                    else        err_set = 1'b1;
                end
            end
            e_mem_cmd: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_ready_i) state_n = e_mem_resp;
            end
            e_mem_resp: begin
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) state_n = cached ? e_data_cmd : e_uc_data_cmd;
            end
            e_data_cmd: begin
                lce_cmd_v_o = 1'b1;
                if (lce_cmd_ready_i) state_n = e_set_tag_cmd;
            end
            e_set_tag_cmd: begin
                lce_cmd_v_o = 1'b1;
                if (lce_cmd_ready_i) state_n = e_wait_ack;
            end
            e_wait_ack: begin
                lce_resp_yumi_o = lce_resp_v_i;
                if (lce_resp_v_i) begin
                    if (ack_ok) state_n = e_ready;
                    else        err_set = 1'b1;
                end
            end
            e_uc_data_cmd: begin
                lce_cmd_v_o = 1'b1;
                if (lce_cmd_ready_i) state_n = e_ready;
            end
            default: state_n = e_ready;
        endcase
        // Unexpected memory responses are drained so they cannot wedge the memory side
        if (state_r != e_mem_resp) begin
            mem_resp_yumi_o = mem_resp_v_i & ~reset_i;
            if (mem_resp_v_i) err_set = 1'b1;
        end
    end

    // Outgoing payloads are built only from registered state
    always_comb begin
        cmd          = '0;
        cmd.dst_id   = src_id_r;
        cmd.src_id   = cce_id_width_p'(cce_id_p);
        cmd.way_id   = lru_way_r;
        cmd.addr     = addr_r;
        cmd.state    = e_COH_I;
        cmd.msg_type = e_lce_cmd_data;
        cmd.data     = data_r;
        if (state_r == e_set_tag_cmd) begin
            cmd.msg_type = e_lce_cmd_set_tag;
            cmd.state    = non_excl_r ? e_COH_S : e_COH_E;
            cmd.data     = '0;
        end else if (state_r == e_uc_data_cmd) begin
            cmd.msg_type = e_lce_cmd_uc_data;
            cmd.data     = cce_block_width_p'(data_r[63:0]);
        end
        mem_cmd          = '0;
        mem_cmd.msg_type = cached ? e_mem_msg_rd : e_mem_msg_uc_rd;
        mem_cmd.size     = cached ? 3'(block_off_lp) : e_mem_size_8;
        mem_cmd.lce_id   = src_id_r;
        mem_cmd.way_id   = lru_way_r;
        mem_cmd.addr     = cached ? {addr_r[paddr_width_p-1:block_off_lp], {block_off_lp{1'b0}}}
                                  : addr_r;
    end

    assign lce_cmd_o = cmd;
    assign mem_cmd_o = mem_cmd;

    // Request field capture on accept
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_r     <= '0;
            src_id_r   <= '0;
            lru_way_r  <= '0;
            msg_type_r <= '0;
            non_excl_r <= 1'b0;
        end else if (state_r == e_ready && lce_req_v_i) begin
            addr_r     <= req.addr;
            src_id_r   <= req.src_id;
            lru_way_r  <= req.lru_way_id;
            msg_type_r <= req.msg_type;
            non_excl_r <= req.non_exclusive;
        end
    end

    // Line buffer loaded on the memory response handshake
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                                      data_r <= '0;
        else if (state_r == e_mem_resp && mem_resp_v_i)   data_r <= mem_resp.data;
    end

    // Sticky protocol-error flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)      error_r <= 1'b0;
        else if (err_set) error_r <= 1'b1;
    end

endmodule

// File: tb/tb_bp_fe_cce_responder.sv
// tb/tb_bp_fe_cce_responder.sv - scoreboard bench for bp_fe_cce_responder
module tb_bp_fe_cce_responder;
    localparam int PADDR = 40;
    localparam int BLK   = 512;
    localparam int REQ_W  = 3 + 4 + 1 + 3 + PADDR;
    localparam int RESP_W = 2 + 4 + PADDR;
    localparam int CMD_W  = 3 + 4 + 4 + 3 + 2 + PADDR + BLK;
    localparam int MEM_W  = 3 + 3 + 4 + 3 + PADDR + BLK;

    logic clk = 1'b0;
    logic reset_i;
    logic [REQ_W-1:0]  lce_req;
    logic              lce_req_v;
    logic              lce_req_yumi_o;
    logic [RESP_W-1:0] lce_resp;
    logic              lce_resp_v;
    logic              lce_resp_yumi_o;
    logic [CMD_W-1:0]  lce_cmd_o;
    logic              lce_cmd_v_o;
    logic              lce_cmd_ready;
    logic [MEM_W-1:0]  mem_cmd_o;
    logic              mem_cmd_v_o;
    logic              mem_cmd_ready;
    logic [MEM_W-1:0]  mem_resp;
    logic              mem_resp_v;
    logic              mem_resp_yumi_o;
    logic              error_o;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_mem_cyc, last_resp_cyc, last_ack_cyc;

    logic [CMD_W-1:0] exp_cmd[$];
    logic [MEM_W-1:0] exp_mem[$];

    bp_fe_cce_responder dut (
        .clk_i(clk), .reset_i(reset_i),
        .lce_req_i(lce_req), .lce_req_v_i(lce_req_v), .lce_req_yumi_o(lce_req_yumi_o),
        .lce_resp_i(lce_resp), .lce_resp_v_i(lce_resp_v), .lce_resp_yumi_o(lce_resp_yumi_o),
        .lce_cmd_o(lce_cmd_o), .lce_cmd_v_o(lce_cmd_v_o), .lce_cmd_ready_i(lce_cmd_ready),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready),
        .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi_o),
        .error_o(error_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    function automatic logic [BLK-1:0] line_of(input logic [PADDR-1:0] a);
        logic [BLK-1:0] l;
        for (int i = 0; i < BLK / 32; i++)
            l[i*32 +: 32] = a[31:0] ^ (32'h0101_0101 * 32'(i)) ^ 32'h5A00_0000;
        return l;
    endfunction

    function automatic logic [CMD_W-1:0] mk_cmd(input logic [2:0] t, input logic [3:0] dst,
                                                 input logic [2:0] w, input logic [1:0] st,
                                                 input logic [PADDR-1:0] a, input logic [BLK-1:0] d);
        return {t, dst, 4'd0, w, st, a, d};
    endfunction

    function automatic logic [MEM_W-1:0] mk_mem(input logic [2:0] t, input logic [2:0] sz,
                                                input logic [3:0] id, input logic [2:0] w,
                                                input logic [PADDR-1:0] a);
        return {t, sz, id, w, a, {BLK{1'b0}}};
    endfunction

    task automatic drive_req(input logic [2:0] t, input logic [PADDR-1:0] a, input logic [3:0] s,
                             input logic [2:0] w, input logic ne, output int acc);
        int n;
        lce_req = {t, s, ne, w, a};
        lce_req_v = 1'b1;
        n = 0;
        @(negedge clk);
        while (!lce_req_yumi_o && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (lce_req_yumi_o !== 1'b1) begin
            fails++; $display("FAIL req_accept: yumi=%b required 1", lce_req_yumi_o);
        end
        acc = cyc;
        @(posedge clk); #1;
        lce_req_v = 1'b0;
    endtask

    task automatic serve_mem(input int stall, input logic [BLK-1:0] line);
        logic [MEM_W-1:0] cap, e;
        int n;
        mem_cmd_ready = (stall == 0);
        n = 0;
        @(negedge clk);
        while (!mem_cmd_v_o && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (mem_cmd_v_o !== 1'b1) begin
            fails++; $display("FAIL mem_cmd_timeout: v=%b required 1", mem_cmd_v_o);
            mem_cmd_ready = 1'b0;
            return;
        end
        cap = mem_cmd_o;
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                checks++;
                if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== cap) begin
                    fails++; $display("FAIL mem_cmd_hold: v=%b cmd=%h required %h", mem_cmd_v_o, mem_cmd_o, cap);
                end
            end
            @(posedge clk); #1;
            mem_cmd_ready = 1'b1;
            @(negedge clk);
        end
        last_mem_cyc = cyc;
        checks++;
        if (exp_mem.size() == 0) begin
            fails++; $display("FAIL mem_cmd_unexpected: cmd=%h required none", mem_cmd_o);
        end else begin
            e = exp_mem.pop_front();
            if (mem_cmd_v_o !== 1'b1 || mem_cmd_o !== e) begin
                fails++; $display("FAIL mem_cmd: v=%b cmd=%h required %h", mem_cmd_v_o, mem_cmd_o, e);
            end
        end
        @(posedge clk); #1;
        mem_cmd_ready = 1'b0;
        mem_resp = {3'd0, 3'd6, 4'd0, 3'd0, {PADDR{1'b0}}, line};
        mem_resp_v = 1'b1;
        @(negedge clk);
        last_resp_cyc = cyc;
        checks++;
        if (mem_resp_yumi_o !== 1'b1) begin
            fails++; $display("FAIL mem_resp_yumi: got %b required 1", mem_resp_yumi_o);
        end
        @(posedge clk); #1;
        mem_resp_v = 1'b0;
    endtask

    task automatic take_cmd(input int stall, output int hs);
        logic [CMD_W-1:0] cap, e;
        int n;
        lce_cmd_ready = (stall == 0);
        n = 0;
        hs = -1;
        @(negedge clk);
        while (!lce_cmd_v_o && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (lce_cmd_v_o !== 1'b1) begin
            fails++; $display("FAIL lce_cmd_timeout: v=%b required 1", lce_cmd_v_o);
            lce_cmd_ready = 1'b0;
            return;
        end
        cap = lce_cmd_o;
        if (stall > 0) begin
            for (int i = 1; i < stall; i++) begin
                @(negedge clk);
                checks++;
                if (lce_cmd_v_o !== 1'b1 || lce_cmd_o !== cap) begin
                    fails++; $display("FAIL lce_cmd_hold: v=%b cmd=%h required %h", lce_cmd_v_o, lce_cmd_o, cap);
                end
            end
            @(posedge clk); #1;
            lce_cmd_ready = 1'b1;
            @(negedge clk);
        end
        hs = cyc;
        checks++;
        if (exp_cmd.size() == 0) begin
            fails++; $display("FAIL lce_cmd_unexpected: cmd=%h required none", lce_cmd_o);
        end else begin
            e = exp_cmd.pop_front();
            if (lce_cmd_v_o !== 1'b1 || lce_cmd_o !== e) begin
                fails++; $display("FAIL lce_cmd: v=%b cmd=%h required %h", lce_cmd_v_o, lce_cmd_o, e);
            end
        end
        @(posedge clk); #1;
        lce_cmd_ready = 1'b0;
    endtask

    task automatic send_ack(input logic [3:0] s, input logic [PADDR-1:0] a);
        lce_resp = {2'd0, s, a};
        lce_resp_v = 1'b1;
        @(negedge clk);
        last_ack_cyc = cyc;
        checks++;
        if (lce_resp_yumi_o !== 1'b1) begin
            fails++; $display("FAIL ack_yumi: got %b required 1", lce_resp_yumi_o);
        end
        @(posedge clk); #1;
        lce_resp_v = 1'b0;
    endtask

    task automatic start_cached(input logic [PADDR-1:0] a, input logic [3:0] s, input logic [2:0] w,
                                input logic ne, input int ms, input int cs,
                                output int acc, output int dc, output int sc);
        logic [PADDR-1:0] al;
        logic [BLK-1:0] line;
        al = {a[PADDR-1:6], 6'd0};
        line = line_of(al);
        exp_mem.push_back(mk_mem(3'd0, 3'd6, s, w, al));
        exp_cmd.push_back(mk_cmd(3'd2, s, w, 2'd0, a, line));
        exp_cmd.push_back(mk_cmd(3'd1, s, w, ne ? 2'd1 : 2'd2, a, {BLK{1'b0}}));
        drive_req(3'd0, a, s, w, ne, acc);
        serve_mem(ms, line);
        take_cmd(cs, dc);
        take_cmd(0, sc);
    endtask

    task automatic pulse_reset();
        #1 reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        exp_cmd.delete();
        exp_mem.delete();
    endtask

    task automatic test_reset();
        lce_req = {3'd0, 4'd1, 1'b0, 3'd0, 40'h1000};
        lce_req_v = 1'b1;
        lce_resp_v = 1'b1;
        mem_resp_v = 1'b1;
        @(negedge clk);
        checks++;
        if ({lce_req_yumi_o, lce_resp_yumi_o, lce_cmd_v_o, mem_cmd_v_o, mem_resp_yumi_o, error_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: req_yumi=%b resp_yumi=%b cmd_v=%b mem_v=%b mresp_yumi=%b err=%b required all 0",
                     lce_req_yumi_o, lce_resp_yumi_o, lce_cmd_v_o, mem_cmd_v_o, mem_resp_yumi_o, error_o);
        end
        lce_req_v = 1'b0;
        lce_resp_v = 1'b0;
        mem_resp_v = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b0;
    endtask

    int cached_acc;

    task automatic test_cached();
        int acc, dc, sc;
        start_cached(40'h80_0000_1234, 4'd1, 3'd3, 1'b1, 0, 0, acc, dc, sc);
        send_ack(4'd1, 40'h80_0000_1234);
        checks++;
        if (last_mem_cyc != acc + 1 || last_resp_cyc != acc + 2 || dc != acc + 3 || sc != acc + 4 || last_ack_cyc != acc + 5) begin
            fails++;
            $display("FAIL cached_timing: mem=%0d resp=%0d data=%0d tag=%0d ack=%0d required +1..+5 from %0d",
                     last_mem_cyc, last_resp_cyc, dc, sc, last_ack_cyc, acc);
        end
        checks++;
        if (error_o !== 1'b0) begin fails++; $display("FAIL cached_error: got %b required 0", error_o); end
        cached_acc = acc;
    endtask

    task automatic test_uncached();
        logic [PADDR-1:0] addrs[2];
        int accs[2];
        int uc;
        logic [BLK-1:0] line;
        addrs[0] = 40'h00_0010_0004;
        addrs[1] = 40'h00_0020_000C;
        for (int k = 0; k < 2; k++) begin
            line = line_of(addrs[k]);
            exp_mem.push_back(mk_mem(3'd1, 3'd3, 4'(k + 2), 3'd5, addrs[k]));
            exp_cmd.push_back(mk_cmd(3'd3, 4'(k + 2), 3'd5, 2'd0, addrs[k], {{(BLK-64){1'b0}}, line[63:0]}));
            drive_req(3'd2, addrs[k], 4'(k + 2), 3'd5, 1'b0, accs[k]);
            serve_mem(0, line);
            take_cmd(0, uc);
            checks++;
            if (uc != accs[k] + 3) begin
                fails++; $display("FAIL uc_data_timing: cycle %0d required %0d", uc, accs[k] + 3);
            end
        end
        checks++;
        if (accs[0] != cached_acc + 6) begin
            fails++; $display("FAIL accept_after_ack: cycle %0d required %0d", accs[0], cached_acc + 6);
        end
        checks++;
        if (accs[1] != accs[0] + 4) begin
            fails++; $display("FAIL uc_back_to_back: cycle %0d required %0d", accs[1], accs[0] + 4);
        end
    endtask

    task automatic test_backpressure();
        int acc, dc, sc;
        start_cached(40'h00_4000_0FC0, 4'd3, 3'd7, 1'b0, 3, 5, acc, dc, sc);
        send_ack(4'd3, 40'h00_4000_0FC0);
        checks++;
        if (sc != dc + 1 || error_o !== 1'b0) begin
            fails++; $display("FAIL backpressure_seq: data=%0d tag=%0d err=%b required tag=data+1 err=0", dc, sc, error_o);
        end
    endtask

    task automatic test_bad_ack();
        int acc, dc, sc, n;
        lce_resp = {2'd0, 4'd0, 40'h12_3456_7800};
        lce_resp_v = 1'b1;
        @(negedge clk);
        checks++;
        if (lce_resp_yumi_o !== 1'b0) begin fails++; $display("FAIL resp_yumi_idle: got %b required 0", lce_resp_yumi_o); end
        @(posedge clk); #1;
        lce_resp_v = 1'b0;
        start_cached(40'h12_3456_7878, 4'd0, 3'd1, 1'b1, 0, 0, acc, dc, sc);
        send_ack(4'd0, 40'h12_3456_7838);
        checks++;
        if (error_o !== 1'b1) begin fails++; $display("FAIL bad_ack_error: got %b required 1", error_o); end
        send_ack(4'd0, 40'h12_3456_7878);
        lce_req = {3'd3, 4'd0, 1'b0, 3'd0, 40'h40};
        lce_req_v = 1'b1;
        @(negedge clk);
        checks++;
        if (lce_req_yumi_o !== 1'b1) begin fails++; $display("FAIL ready_after_ack: yumi=%b required 1", lce_req_yumi_o); end
        @(posedge clk); #1;
        lce_req_v = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (mem_cmd_v_o) n++; end
        checks++;
        if (n != 0) begin fails++; $display("FAIL bad_type_no_mem: mem_cmd_v cycles=%0d required 0", n); end
    endtask

    task automatic test_stray_mem();
        pulse_reset();
        checks++;
        if (error_o !== 1'b0) begin fails++; $display("FAIL error_cleared: got %b required 0", error_o); end
        mem_resp_v = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_resp_yumi_o !== 1'b1) begin fails++; $display("FAIL stray_mem_yumi: got %b required 1", mem_resp_yumi_o); end
        @(posedge clk); #1;
        mem_resp_v = 1'b0;
        @(negedge clk);
        checks++;
        if (error_o !== 1'b1 || mem_cmd_v_o !== 1'b0) begin
            fails++; $display("FAIL stray_mem_error: err=%b mem_v=%b required 1 0", error_o, mem_cmd_v_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int acc, dc, sc, n;
        pulse_reset();
        start_cached(40'h00_0ABC_0040, 4'd2, 3'd2, 1'b0, 0, 0, acc, dc, sc);
        lce_resp = {2'd0, 4'd2, 40'h00_0ABC_0040};
        lce_resp_v = 1'b1;
        #2;
        checks++;
        if (lce_resp_yumi_o !== 1'b1) begin fails++; $display("FAIL wait_ack_yumi: got %b required 1", lce_resp_yumi_o); end
        reset_i = 1'b1;
        #1;
        checks++;
        if ({lce_req_yumi_o, lce_resp_yumi_o, lce_cmd_v_o, mem_cmd_v_o, mem_resp_yumi_o, error_o} !== 6'b0) begin
            fails++; $display("FAIL async_reset_drop: resp_yumi=%b cmd_v=%b mem_v=%b required 0",
                              lce_resp_yumi_o, lce_cmd_v_o, mem_cmd_v_o);
        end
        @(posedge clk); #1;
        lce_resp_v = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (lce_cmd_v_o || mem_cmd_v_o) n++; end
        checks++;
        if (n != 0) begin fails++; $display("FAIL abandoned_cmds: valid cycles=%0d required 0", n); end
        @(posedge clk); #1;
        start_cached(40'h00_0DEF_0100, 4'd1, 3'd4, 1'b1, 0, 0, acc, dc, sc);
        send_ack(4'd1, 40'h00_0DEF_0100);
        checks++;
        if (error_o !== 1'b0 || exp_cmd.size() != 0 || exp_mem.size() != 0) begin
            fails++; $display("FAIL post_reset_txn: err=%b pending cmd=%0d mem=%0d required 0 0 0",
                              error_o, exp_cmd.size(), exp_mem.size());
        end
    endtask

    initial begin
        reset_i = 1'b1;
        lce_req = '0; lce_req_v = 1'b0;
        lce_resp = '0; lce_resp_v = 1'b0;
        lce_cmd_ready = 1'b0; mem_cmd_ready = 1'b0;
        mem_resp = '0; mem_resp_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_cached();
        test_uncached();
        test_backpressure();
        test_bad_ack();
        test_stray_mem();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
